// File: rtl/mem_responder.sv
// mem_responder: word-addressed shared instruction/data memory acting as the
// responder for the multicycle controller's memory requests. Each accepted
// request is answered after LATENCY wait cycles with a one-cycle rsp_valid
// pulse. Misaligned and out-of-range accesses respond with rsp_err=1 and never
// touch the array.
//
// Optional build macro: MEM_BYTE_STROBE_EN adds req_be[3:0] write byte enables.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder idle, request will be accepted
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   req_be     byte enables (MEM_BYTE_STROBE_EN only)
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  read data, valid with rsp_valid
//   rsp_err    access error, valid with rsp_valid
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS),
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam bit         ZeroLat = (LATENCY == 0);
  localparam logic [3:0] CntInit = ZeroLat ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  logic [AW-1:0] cur_idx;
  logic        cur_err, mem_we;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  // With zero latency the response edge is the accept edge, so the live
  // request is used directly instead of the (not yet loaded) capture registers.
  assign cur_we    = ZeroLat ? req_we    : we_q;
  assign cur_addr  = ZeroLat ? req_addr  : addr_q;
  assign cur_wdata = ZeroLat ? req_wdata : wdata_q;

`ifdef MEM_BYTE_STROBE_EN
  logic [3:0] be_q;
  assign cur_be = ZeroLat ? req_be : be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q <= 4'h0;
    end else if (accept) begin
      be_q <= req_be;
    end
  end
`else
  assign cur_be = 4'hF;
`endif

  assign cur_idx = cur_addr[AW+1:2];
  assign cur_err = (|cur_addr[1:0]) | (|cur_addr[31:AW+2]);
  // rst_n gate stops a zero-latency accept during reset from writing.
  assign mem_we  = enter_resp & cur_we & ~cur_err & rst_n;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ZeroLat) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_err || cur_we) ? 32'h0 : mem[cur_idx];
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array
// reference model. Build with MEM_BYTE_STROBE_EN to exercise byte enables.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned NPRE  = 64;  // words preloaded and used by random traffic

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'hF;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_pulse  = 0;

  logic [31:0] model [DEPTH];

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef MEM_BYTE_STROBE_EN
    .req_be   (req_be),
`endif
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_valid) n_pulse++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_junk();
    req_valid = 1'b1;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  // Called just after a rising edge with the DUT idle. Returns observed read data.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit noisy, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          idx;
    exp_err   = (addr % 4 != 0) || (addr >= DEPTH * 4);
    idx       = int'(addr / 4);
    exp_rdata = 32'h0;
    if (!exp_err && !we) exp_rdata = model[idx];
    got = 32'h0;
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    n_acc++;
    if (noisy) drive_junk(); else req_valid = 1'b0;
    for (int k = 0; k <= int'(LAT); k++) begin
      if (k < int'(LAT)) begin
        check("busy_ready", 32'(req_ready), 32'd0);
        check("early_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("resp_ready", 32'(req_ready), 32'd0);
        got = rsp_rdata;
      end
      if (noisy) drive_junk();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    if (!exp_err && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a, w;
    logic [3:0]  be;
    logic        we;
    int          kind;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Preload the words used below so every read has a known expectation.
    for (int i = 0; i < int'(NPRE); i++) begin
      do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, got);
    end

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, got);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, got);
    check("rd_deadbeef", got, 32'hDEADBEEF);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, 1'b0, got);
    do_req(1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, got);
    do_req(1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, got);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, got);

    // Random traffic, with req_valid held high and changing while busy.
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      we   = 1'($urandom);
      w    = $urandom;
      a    = 32'($urandom_range(0, NPRE - 1)) * 4;
`ifdef MEM_BYTE_STROBE_EN
      be   = 4'($urandom);
`else
      be   = 4'hF;
`endif
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      else if (kind == 9) a = a | (32'($urandom_range(1, 1023)) << 12);
      do_req(we, a, w, be, 1'($urandom), got);
    end

    // Reset while a write waits: no response, write dropped.
    do_req(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0, got);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, got);
    check("rst_drop_write", got, 32'h11111111);

`ifdef MEM_BYTE_STROBE_EN
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, got);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, got);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, got);
    check("be_merge", got, 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, got);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, got);
    check("be_noop", got, 32'h11BB33DD);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("pulse_count", 32'(n_pulse), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
